seq_tracker: RTL
================

Name: seq_tracker

Overview:
- Sequence memory and checker for the Genius game.
- Consumes the 2-bit colour values from the random number generator and appends one colour per round.
- Replays the stored sequence to the display/tone logic over a valid/ready handshake, then checks the player's button presses against it.
- Sits between the RNG and the top-level game FSM; reports round pass/fail to the FSM.

Parameters:
DATA_WIDTH, 2, width of one colour symbol; matches RNG output width
MAX_LEN, 32, maximum sequence length in symbols
LEN_WIDTH, 6, width of length/index counters; must satisfy 2**LEN_WIDTH > MAX_LEN

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
rng_in  input  DATA_WIDTH  current RNG output colour
append  input  1  pulse: store rng_in at position seq_len
start  input  1  pulse: begin playback of the stored sequence
clear  input  1  pulse: empty the sequence, return to IDLE
play_valid  output  1  playback symbol available
play_data  output  DATA_WIDTH  playback symbol
play_ready  input  1  consumer accepts play_data
btn_valid  input  1  pulse: player pressed a button (debounced, one cycle)
btn_data  input  DATA_WIDTH  colour of the pressed button
busy  output  1  high when state is not IDLE
seq_len  output  LEN_WIDTH  number of stored symbols
full  output  1  seq_len == MAX_LEN
round_ok  output  1  one-cycle pulse: full sequence entered correctly
fail  output  1  one-cycle pulse: wrong button pressed

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, seq_len=0, idx=0.
  - All outputs 0: play_valid, play_data, busy, full, round_ok, fail.
  - Memory contents are don't-care.
- Storage:
  - Register array of MAX_LEN x DATA_WIDTH.
  - Combinational read at idx.
  - play_data = mem[idx] while play_valid=1, otherwise 0.
- Priority: rst > clear > state-specific inputs.
- clear, in any state: seq_len<=0, idx<=0, state<=IDLE. Any pending playback or check is aborted with no round_ok/fail pulse.
- IDLE:
  - append with full=0: mem[seq_len]<=rng_in, seq_len++.
  - append with full=1: ignored; seq_len and memory unchanged.
  - start with seq_len>0: idx<=0, state<=PLAY.
  - start with seq_len==0: ignored.
  - append and start in the same cycle: append is performed, start is ignored.
  - btn_valid and play_ready are ignored.
- PLAY:
  - play_valid=1.
  - A symbol transfers on a cycle with play_valid && play_ready.
  - On transfer: if idx==seq_len-1 then idx<=0 and state<=CHECK; else idx++.
  - play_data is held stable while play_ready=0.
  - Consecutive transfers are allowed: one symbol per cycle with play_ready tied high.
  - append, start and btn_valid are ignored.
- CHECK:
  - play_valid=0.
  - On btn_valid: compare btn_data with mem[idx].
  - Mismatch: fail=1 next cycle; state<=IDLE; idx<=0; seq_len unchanged.
  - Match with idx==seq_len-1: round_ok=1 next cycle; state<=IDLE; idx<=0.
  - Match otherwise: idx++.
  - append and start are ignored.
  - No timeout in this block; the game FSM owns timeouts and uses clear.
- Latency:
  - btn_valid at edge N -> round_ok/fail high for exactly the cycle after edge N+1.
  - state is IDLE from that same cycle.
- busy = (state != IDLE), registered.
- full = (seq_len == MAX_LEN), registered and updated with seq_len.
- seq_len never exceeds MAX_LEN and never wraps.

Test Plan:
- Reset then append x3 with rng_in=2,0,3 -> seq_len=3, full=0, busy=0, no pulses.
- From that state, start with play_ready=1 -> play_valid high 3 cycles, play_data=2,0,3, then busy stays 1 with state CHECK; buttons 2,0,3 -> round_ok single pulse one cycle after the 3rd press, busy=0, seq_len=3.
- Same sequence, play_ready toggled 1,0,0,1,1 -> play_data held at 0 during stall cycles, exactly 3 transfers; buttons 2,1 -> fail pulse after the 2nd press, no round_ok, seq_len=3, busy=0.
- Append MAX_LEN+2 times (32+2) -> seq_len=32, full=1 after the 32nd; the extra appends leave seq_len and mem[31] unchanged.
- clear asserted mid-PLAY (after 1 transfer) and mid-CHECK -> next cycle state IDLE, seq_len=0, play_valid=0, no round_ok/fail; a following start is ignored.
- append+start same cycle with seq_len=0 -> seq_len=1, busy=0; start alone next -> playback of 1 symbol; rst mid-CHECK -> all outputs 0, seq_len=0.

Source files
------------

// File: rtl/seq_tracker.sv
// seq_tracker: stores the Genius colour sequence, replays it over valid/ready and checks player presses
module seq_tracker #(
  parameter int DATA_WIDTH = 2,
  parameter int MAX_LEN    = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rng_in,
  input  logic                  append,
  input  logic                  start,
  input  logic                  clear,
  output logic                  play_valid,
  output logic [DATA_WIDTH-1:0] play_data,
  input  logic                  play_ready,
  input  logic                  btn_valid,
  input  logic [DATA_WIDTH-1:0] btn_data,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  seq_len,
  output logic                  full,
  output logic                  round_ok,
  output logic                  fail
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, CHECK} state_t;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [MAX_LEN];
  logic [LEN_WIDTH-1:0]  r_len, r_idx;
  logic                  r_ok, r_fail;
  logic [DATA_WIDTH-1:0] w_cur;
  logic                  w_last, w_full;
  assign w_cur      = r_mem[r_idx[AW-1:0]];
  assign w_last     = r_idx == r_len - LEN_WIDTH'(1);
  assign w_full     = r_len == LEN_WIDTH'(MAX_LEN);
  assign play_valid = r_state == PLAY;
  assign play_data  = play_valid ? w_cur : '0;
  assign busy       = r_state != IDLE;
  assign seq_len    = r_len;
  assign full       = w_full;
  assign round_ok   = r_ok;
  assign fail       = r_fail;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_ok    <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_ok   <= 1'b0;
      r_fail <= 1'b0;
      if (clear) begin
        r_state <= IDLE;
        r_len   <= '0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            // an append in the same cycle always suppresses start, even when full
            if (append) begin
              if (!w_full) begin
                r_mem[r_len[AW-1:0]] <= rng_in;
                r_len                <= r_len + 1'b1;
              end
            end else if (start && r_len != '0) begin
              r_idx   <= '0;
              r_state <= PLAY;
            end
          end
          PLAY: begin
            if (play_ready) begin
              r_idx   <= w_last ? '0 : r_idx + 1'b1;
              r_state <= w_last ? CHECK : PLAY;
            end
          end
          CHECK: begin
            if (btn_valid) begin
              if (btn_data != w_cur) begin
                r_fail  <= 1'b1;
                r_state <= IDLE;
                r_idx   <= '0;
              end else if (w_last) begin
                r_ok    <= 1'b1;
                r_state <= IDLE;
                r_idx   <= '0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
